// File: rtl/pattern_scan_ctrl.sv
// Scan controller: accepts a word and pattern over valid/ready, shifts the word MSB-first
// through an overlapping Moore-style detector, counts matches and pulses done at the end.
// Optional feature: define SCAN_ABORT_EN to add an abort input that cancels a scan in
// SHIFT or FLUSH.
module pattern_scan_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SCAN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  output logic              busy,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done
);

  localparam int unsigned IdxW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned FillW = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StFlush, StDone} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  word_q;
  logic [PAT_W-1:0]   pat_q;
  logic [PAT_W-1:0]   hist_q;
  logic [FillW-1:0]   fill_q;
  logic [IdxW-1:0]    idx_q;
  logic               match_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               cur_bit;
  logic [PAT_W-1:0]   hist_nxt;
  logic [FillW-1:0]   fill_nxt;
  logic               hit;
  logic               abort_hit;

  // Detector view of the bit being shifted this cycle.
  always_comb begin
    cur_bit  = word_q[idx_q];
    hist_nxt = {hist_q[PAT_W-2:0], cur_bit};
    fill_nxt = (fill_q == FillW'(PAT_W)) ? fill_q : fill_q + 1'b1;
    hit      = (fill_nxt == FillW'(PAT_W)) && (hist_nxt == pat_q);
`ifdef SCAN_ABORT_EN
    abort_hit = abort && ((state_q == StShift) || (state_q == StFlush));
`else
    abort_hit = 1'b0;
`endif
  end

  // Outputs decoded from registered state; bit_out is held low outside SHIFT.
  always_comb begin
    start_ready = (state_q == StIdle);
    busy        = (state_q != StIdle);
    bit_valid   = (state_q == StShift);
    bit_out     = (state_q == StShift) ? cur_bit : 1'b0;
    done        = (state_q == StDone);
    match       = match_q;
    match_cnt   = cnt_q;
  end

  // Scan FSM with the detector history, fill count and saturating match counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else if (abort_hit) begin
      state_q <= StIdle;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          match_q <= 1'b0;
          if (start_valid) begin
            word_q  <= data_in;
            pat_q   <= pattern;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= IdxW'(DATA_W - 1);
            state_q <= StShift;
          end
        end
        StShift: begin
          hist_q  <= hist_nxt;
          fill_q  <= fill_nxt;
          match_q <= hit;
          if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (idx_q == '0) begin
            state_q <= StFlush;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StFlush: begin
          match_q <= 1'b0;
          state_q <= StDone;
        end
        StDone: begin
          match_q <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          match_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: per-cycle checks of the serial stream, match
// pulses, done timing and counts; a second instance with CNT_W = 3 covers saturation.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic [15:0] data_in;
  logic [3:0]  pattern;
`ifdef SCAN_ABORT_EN
  logic        abort;
`endif

  logic        start_ready, busy, bit_out, bit_valid, match, done;
  logic [4:0]  match_cnt;
  logic        s_ready, s_busy, s_bit_out, s_bit_valid, s_match, s_done;
  logic [2:0]  s_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.DATA_W(16), .PAT_W(4), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SCAN_ABORT_EN
    .abort      (abort),
`endif
    .start_valid(start_valid),
    .start_ready(start_ready),
    .data_in    (data_in),
    .pattern    (pattern),
    .busy       (busy),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .match      (match),
    .match_cnt  (match_cnt),
    .done       (done)
  );

  pattern_scan_ctrl #(.DATA_W(16), .PAT_W(4), .CNT_W(3)) dut_sat (
    .clk        (clk),
    .rst        (rst),
`ifdef SCAN_ABORT_EN
    .abort      (abort),
`endif
    .start_valid(start_valid),
    .start_ready(s_ready),
    .data_in    (data_in),
    .pattern    (pattern),
    .busy       (s_busy),
    .bit_out    (s_bit_out),
    .bit_valid  (s_bit_valid),
    .match      (s_match),
    .match_cnt  (s_cnt),
    .done       (s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk = n_chk + 1;
    assert (obs === exp_v) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream bit j is w[15-j]; a match completes at bit i when bits i-3..i equal p.
  function automatic logic win_match(input logic [15:0] w, input logic [3:0] p, input int i);
    logic [15:0] sh;
    if (i < 3) return 1'b0;
    sh = w >> (15 - i);
    return (sh[3:0] == p);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, start_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bit_out"}, bit_out, 0);
    chk({tag, "_bit_valid"}, bit_valid, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_cnt"}, match_cnt, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Called in an IDLE cycle; accepts on the next edge and follows the scan to IDLE.
  task automatic scan(input logic [15:0] w, input logic [3:0] p, input int exp_cnt,
                      input int exp_sat, input bit hold);
    logic prev;
    data_in     = w;
    pattern     = p;
    start_valid = 1'b1;
    chk("idle_ready", start_ready, 1);
    tick();
    if (!hold) start_valid = 1'b0;
    data_in = ~w;
    pattern = ~p;
    prev    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("shift_valid", bit_valid, 1);
      chk("shift_bit", bit_out, w[15-i]);
      chk("shift_match", match, prev);
      chk("shift_busy", busy, 1);
      chk("shift_ready", start_ready, 0);
      chk("shift_done", done, 0);
      prev = win_match(w, p, i);
      tick();
    end
    chk("flush_valid", bit_valid, 0);
    chk("flush_match", match, prev);
    chk("flush_done", done, 0);
    chk("flush_busy", busy, 1);
    tick();
    chk("done_pulse", done, 1);
    chk("done_match", match, 0);
    chk("done_ready", start_ready, 0);
    chk("done_cnt", match_cnt, exp_cnt);
    chk("done_cnt_sat", s_cnt, exp_sat);
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_ready", start_ready, 1);
    chk("post_cnt_held", match_cnt, exp_cnt);
  endtask

  initial begin
    rst         = 1'b0;
    start_valid = 1'b0;
    data_in     = 16'h0;
    pattern     = 4'h0;
`ifdef SCAN_ABORT_EN
    abort       = 1'b0;
`endif
    #2;
    check_reset_vals("rst0");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_vals("idle0");

    // Overlapping matches: bits 3, 6, 9, 12.
    scan(16'hDB68, 4'b1101, 4, 4, 1'b0);
    // No match, timing only.
    scan(16'h0000, 4'b1101, 0, 0, 1'b0);
    // 13 matches: saturates at 7 on the 3-bit counter.
    scan(16'hFFFF, 4'b1111, 13, 7, 1'b0);
    // Back-to-back with start_valid held; second word must not see the first's history.
    scan(16'hDB68, 4'b1101, 4, 4, 1'b1);
    scan(16'hFFFF, 4'b1101, 0, 0, 1'b0);

    // Asynchronous reset mid-scan.
    data_in     = 16'hDB68;
    pattern     = 4'b1101;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (6) tick();
    chk("pre_rst_cnt", match_cnt, 1);
    rst = 1'b0;
    #1;
    check_reset_vals("rst_async");
    tick();
    tick();
    check_reset_vals("rst_hold");
    #2;
    rst = 1'b1;
    tick();
    check_reset_vals("rst_release");
    tick();
    chk("rst_no_done", done, 0);
    scan(16'hDB68, 4'b1101, 4, 4, 1'b0);

`ifdef SCAN_ABORT_EN
    // Abort on the 5th SHIFT cycle, after the first match was counted.
    data_in     = 16'hDB68;
    pattern     = 4'b1101;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (4) tick();
    chk("abort_pre_match", match, 1);
    chk("abort_pre_cnt", match_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_reset_vals("abort_idle");
    scan(16'hDB68, 4'b1101, 4, 4, 1'b0);
    // Abort in IDLE is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_cnt", match_cnt, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
